// File: rtl/uart_rx_parity_checker_if.sv
// uart_rx_parity_checker_if: serial line in, decoded word and status out
//   rx_i           serial line, idle high
//   data_o         last received 32-bit word, bit 0 = first data bit
//   data_valid_o   one-cycle pulse per completed frame
//   parity_error_o received parity differs from even parity of data_o
//   frame_error_o  stop bit sampled low
//   busy_o         frame in progress
interface uart_rx_parity_checker_if;
    logic        rx_i;
    logic [31:0] data_o;
    logic        data_valid_o;
    logic        parity_error_o;
    logic        frame_error_o;
    logic        busy_o;
    modport master (output rx_i, input data_o, data_valid_o, parity_error_o, frame_error_o, busy_o);
    modport slave (input rx_i, output data_o, data_valid_o, parity_error_o, frame_error_o, busy_o);
endinterface

// File: rtl/uart_rx_parity_checker.sv
// uart_rx_parity_checker: 32-bit even-parity UART receiver with frame/parity status
//   clk  sole clock, rising edge
//   rst  synchronous active-high reset
//   bus  slave side of uart_rx_parity_checker_if (rx_i in, word/status out)
module uart_rx_parity_checker #(
    parameter int CLKS_PER_BIT = 16
) (
    input logic                      clk,
    input logic                      rst,
    uart_rx_parity_checker_if.slave  bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID = CW'(CLKS_PER_BIT / 2 - 1);

    if (CLKS_PER_BIT < 4 || CLKS_PER_BIT % 2 != 0) begin : g_bad_param
        $error("CLKS_PER_BIT must be even and >= 4");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync_q;
    logic          rx_s, rx_prev_q;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [5:0]    bit_cnt_q, bit_cnt_d;
    logic [31:0]   shift_q, shift_d, data_q, data_d;
    logic          parity_q, parity_d, perr_q, perr_d, ferr_q, ferr_d, valid_q, valid_d;
    logic          tick;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            data_q    <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], bus.rx_i};
            rx_prev_q <= rx_s;
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            data_q    <= data_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            valid_q   <= valid_d;
        end
    end

    // The bit-period counter is cleared on the detected edge, so START waits
    // half a period to the start-bit centre and every later state a full one.
    always_comb begin
        state_d   = state_q;
        tick      = clk_cnt_q == LAST;
        clk_cnt_d = tick ? '0 : clk_cnt_q + CW'(1);
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        data_d    = data_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        valid_d   = 1'b0;
        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                state_d   = (rx_prev_q && !rx_s) ? START : IDLE;
            end
            START: if (clk_cnt_q == MID) begin
                clk_cnt_d = '0;
                state_d   = rx_s ? IDLE : DATA;
            end
            DATA: if (tick) begin
                shift_d   = {rx_s, shift_q[31:1]};
                bit_cnt_d = bit_cnt_q + 6'd1;
                state_d   = (bit_cnt_q == 6'd31) ? PARITY : DATA;
            end
            PARITY: if (tick) begin
                parity_d = rx_s;
                state_d  = STOP;
            end
            STOP: if (tick) begin
                data_d  = shift_q;
                perr_d  = parity_q ^ (^shift_q);
                ferr_d  = !rx_s;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.data_o         = data_q;
    assign bus.data_valid_o   = valid_q;
    assign bus.parity_error_o = perr_q;
    assign bus.frame_error_o  = ferr_q;
    assign bus.busy_o         = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_parity_checker.sv
// tb_uart_rx_parity_checker: frame-level model of the receiver checked every cycle
module tb_uart_rx_parity_checker;
    localparam int N = 16;
    localparam int H = N / 2;

    typedef struct {
        int          lo;
        int          hi;
        bit          v;
        logic [31:0] d;
        bit          pe;
        bit          fe;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    logic rst_seen = 1'b0;
    int   total = 0;
    int   bad = 0;
    ev_t  q[$];
    int   vcyc[$];
    logic [31:0] exp_d = '0;
    logic        exp_pe = 1'b0, exp_fe = 1'b0, eb, ev;

    uart_rx_parity_checker_if bus ();
    uart_rx_parity_checker #(.CLKS_PER_BIT(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h want %h", n, cyc, a, e);
        end
    endtask

    // Line timing: rx change in cycle P reaches the decoder in cycle P+2 (the
    // edge cycle T); busy covers T+1..last sample; valid is the cycle after.
    always @(negedge clk) if (cyc > 0) begin
        eb = 1'b0;
        ev = 1'b0;
        if (rst_seen) begin
            q.delete();
            exp_d  = '0;
            exp_pe = 1'b0;
            exp_fe = 1'b0;
        end else if (q.size() > 0) begin
            if (cyc >= q[0].lo && cyc <= q[0].hi) eb = 1'b1;
            if (cyc == q[0].hi + 1) begin
                if (q[0].v) begin
                    ev     = 1'b1;
                    exp_d  = q[0].d;
                    exp_pe = q[0].pe;
                    exp_fe = q[0].fe;
                end
                void'(q.pop_front());
            end
        end
        chk("busy", 32'(bus.busy_o), 32'(eb));
        chk("valid", 32'(bus.data_valid_o), 32'(ev));
        chk("data", bus.data_o, exp_d);
        chk("parity_err", 32'(bus.parity_error_o), 32'(exp_pe));
        chk("frame_err", 32'(bus.frame_error_o), 32'(exp_fe));
        if (bus.data_valid_o === 1'b1) vcyc.push_back(cyc);
    end

    // Called at posedge+1; drives frame bits 0..last-1 for full periods, and
    // bit 'last' for half a period when the frame is cut short.
    task automatic send(input logic [31:0] d, input logic par, input logic stp, input int last);
        logic [34:0] fr;
        ev_t e;
        fr   = {stp, par, d, 1'b0};
        e.lo = cyc + 3;
        e.hi = cyc + 2 + H + 34 * N;
        e.v  = 1'b1;
        e.d  = d;
        e.pe = par != ^d;
        e.fe = !stp;
        q.push_back(e);
        for (int k = 0; k < last; k++) begin
            bus.rx_i = fr[k];
            repeat (N) begin @(posedge clk); #1; end
        end
        if (last < 35) begin
            bus.rx_i = fr[last];
            repeat (H) begin @(posedge clk); #1; end
        end
    endtask

    task automatic idle(input int n);
        bus.rx_i = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        int nv;
        ev_t g;
        bus.rx_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(4);
        chk("reset_data", bus.data_o, 32'h0);
        chk("reset_busy", 32'(bus.busy_o), 32'h0);

        nv = vcyc.size();
        send(32'hA5A50F0F, 1'b0, 1'b1, 35);
        idle(10);
        chk("clean_data", bus.data_o, 32'hA5A50F0F);
        chk("clean_flags", {30'h0, bus.parity_error_o, bus.frame_error_o}, 32'h0);
        chk("clean_busy", 32'(bus.busy_o), 32'h0);
        chk("clean_pulses", 32'(vcyc.size() - nv), 32'd1);

        send(32'hA5A50F0F, 1'b1, 1'b1, 35);
        idle(10);
        chk("par_data", bus.data_o, 32'hA5A50F0F);
        chk("par_flags", {30'h0, bus.parity_error_o, bus.frame_error_o}, 32'h2);

        nv = vcyc.size();
        send(32'h00000001, 1'b1, 1'b0, 35);
        bus.rx_i = 1'b0;
        repeat (60) begin @(posedge clk); #1; end
        chk("stop_data", bus.data_o, 32'h00000001);
        chk("stop_flags", {30'h0, bus.parity_error_o, bus.frame_error_o}, 32'h1);
        chk("stop_no_retrigger", 32'(vcyc.size() - nv), 32'd1);
        idle(10);

        nv = vcyc.size();
        g.lo = cyc + 3;
        g.hi = cyc + 2 + H;
        g.v  = 1'b0;
        g.d  = '0;
        g.pe = 1'b0;
        g.fe = 1'b0;
        q.push_back(g);
        bus.rx_i = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        chk("glitch_busy", 32'(bus.busy_o), 32'h1);
        idle(20);
        chk("glitch_no_valid", 32'(vcyc.size() - nv), 32'd0);
        chk("glitch_hold", bus.data_o, 32'h00000001);

        nv = vcyc.size();
        send(32'hFFFFFFFF, 1'b0, 1'b1, 11);
        rst = 1'b1;
        bus.rx_i = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midreset_data", bus.data_o, 32'h0);
        chk("midreset_flags", {29'h0, bus.busy_o, bus.parity_error_o, bus.frame_error_o}, 32'h0);
        idle(20);
        chk("midreset_no_valid", 32'(vcyc.size() - nv), 32'd0);
        send(32'hFFFFFFFF, 1'b0, 1'b1, 35);
        idle(10);
        chk("ones_data", bus.data_o, 32'hFFFFFFFF);
        chk("ones_flags", {30'h0, bus.parity_error_o, bus.frame_error_o}, 32'h0);

        nv = vcyc.size();
        send(32'h12345678, 1'b1, 1'b1, 35);
        send(32'h00000000, 1'b0, 1'b1, 35);
        idle(10);
        chk("b2b_pulses", 32'(vcyc.size() - nv), 32'd2);
        if (vcyc.size() - nv == 2) chk("b2b_spacing", 32'(vcyc[nv + 1] - vcyc[nv]), 32'd560);
        chk("b2b_data", bus.data_o, 32'h0);
        chk("b2b_flags", {30'h0, bus.parity_error_o, bus.frame_error_o}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_parity_checker.md
UART_RX_PARITY_CHECKER -- requirements
Module: uart_rx_parity_checker

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; SHALL be even and >= 4.
REQ-002 Clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset, sampled on rising Clk.
REQ-004 Rx_In  input  1  asynchronous serial line, idle high.
REQ-005 Data_Out  output  32  last received data word, bit 0 = first data bit on the line.
REQ-006 Data_Valid  output  1  one-cycle pulse marking a completed frame.
REQ-007 Parity_Error  output  1  received parity bit != XOR of the 32 received data bits.
REQ-008 Frame_Error  output  1  stop bit sampled low.
REQ-009 Busy  output  1  high while a frame is in progress.

Function
REQ-010 Frame format SHALL be: 1 start bit (0), 32 data bits LSB first, 1 parity bit, 1 stop bit (1); 35 bit periods total.
REQ-011 Parity SHALL be even: expected parity bit = XOR of Data bits, so total ones over data plus parity is even.
REQ-012 Rx_In SHALL pass through a 2-flop synchronizer; both flops SHALL reset to 1; all decoding SHALL use the synchronized value Rx_S.
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; no other reachable states.
REQ-014 IDLE -> START SHALL occur only on a falling edge of Rx_S (previous 1, current 0); a line held low does not retrigger.
REQ-015 With T = cycle of the detected falling edge, sample k (k=0 start, 1..32 data, 33 parity, 34 stop) SHALL occur at T + CLKS_PER_BIT/2 + k*CLKS_PER_BIT.
REQ-016 START: if sample 0 reads 1 (false start), FSM SHALL return to IDLE with no Data_Valid and no output change.
REQ-017 DATA: 6-bit bit counter; after sample 32, FSM SHALL enter PARITY; data SHALL shift into a 32-bit register LSB first.
REQ-018 PARITY: SHALL store the sampled bit, then enter STOP.
REQ-019 STOP: on sample 34, FSM SHALL return to IDLE in the next cycle.
REQ-020 In the cycle after sample 34, Data_Valid SHALL be 1 for exactly one cycle; Data_Out, Parity_Error and Frame_Error SHALL be updated in that same cycle.
REQ-021 Data_Out, Parity_Error and Frame_Error SHALL hold their values until the next Data_Valid or Reset.
REQ-022 Data_Valid SHALL pulse on every completed frame, including frames with parity and/or framing errors.
REQ-023 Busy SHALL be 1 from the cycle after the falling-edge detect until the cycle the FSM re-enters IDLE; it SHALL be 0 in IDLE.
REQ-024 Back-to-back frames: a falling edge detected in the first IDLE cycle after STOP SHALL start a new frame.
REQ-025 After a frame error with the line still low, no new frame SHALL start until Rx_S returns high and falls again.

Reset
REQ-026 With Reset high, on the next rising Clk: FSM = IDLE, counters = 0, shift register = 0, synchronizer = 1.
REQ-027 With Reset high, on the next rising Clk: Data_Out = 0, Data_Valid = 0, Parity_Error = 0, Frame_Error = 0, Busy = 0.
REQ-028 Reset mid-frame SHALL abandon the partial frame with no Data_Valid; Reset SHALL take priority over every other event in the same cycle.

Verification (CLKS_PER_BIT = 16)
REQ-029 Clean frame: 0xA5A50F0F, parity 0, stop 1 -> Data_Out=0xA5A50F0F, single Data_Valid pulse, both error flags 0, Busy low afterwards.
REQ-030 Bad parity: 0xA5A50F0F, parity 1 -> Data_Valid pulse, Data_Out=0xA5A50F0F, Parity_Error=1, Frame_Error=0.
REQ-031 Bad stop: 0x00000001, parity 1, stop 0 -> Frame_Error=1, Parity_Error=0, Data_Out=0x00000001.
REQ-032 Glitch: Rx_In low for 5 cycles on an idle line -> Busy pulses, no Data_Valid, outputs unchanged.
REQ-033 Reset during data bit 10 -> outputs all 0 the next cycle, no Data_Valid; a following clean frame 0xFFFFFFFF, parity 0 -> Data_Out=0xFFFFFFFF, no errors.
REQ-034 Two back-to-back frames, 0x12345678 (parity 1) then 0x00000000 (parity 0), no idle gap -> two Data_Valid pulses exactly 35*16 cycles apart with the correct words and no errors.
